// File: rtl/vdp_host_seq_if.sv
// Host command/response and VDP byte-port signals for vdp_host_seq.
// The slave modport is the sequencer, the master modport is host plus VDP.
interface vdp_host_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [13:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        wr_tick;
    logic        rd_tick;
    logic        mode;
    logic [7:0]  dout;
    logic [7:0]  din;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, din,
        output cmd_ready, rsp_valid, rsp_data,
        output wr_tick, rd_tick, mode, dout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, din,
        input  cmd_ready, rsp_valid, rsp_data,
        input  wr_tick, rd_tick, mode, dout
    );
endinterface

// File: rtl/vdp_host_seq.sv
// Host-side VDP access sequencer: turns commands into paced byte ticks
// and skips address setup when the VDP auto-increment already points there.
module vdp_host_seq #(
    parameter int unsigned GAP = 4
) (
    input  logic          pxclk,
    input  logic          reset,
    vdp_host_seq_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR_LO = 3'd1;
    localparam logic [2:0] ADDR_HI = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] GAPWAIT = 3'd4;

    localparam logic [1:0] OP_REG  = 2'd0;
    localparam logic [1:0] OP_VWR  = 2'd1;
    localparam logic [1:0] OP_VRD  = 2'd2;
    localparam logic [1:0] OP_STAT = 2'd3;

    // Counter holds idle cycles still owed; it reads 0 on cycle T+GAP.
    localparam logic [7:0] GAP_LD =
        (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  next_q, next_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [13:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [13:0] sh_addr_q, sh_addr_d;
    logic        sh_rd_q, sh_rd_d;
    logic        sh_vld_q, sh_vld_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [7:0]  rsp_dat_q, rsp_dat_d;

    logic       st_lo, st_hi, st_data;
    logic       tick, is_rd, accept, hit;
    logic [2:0] follow;
    logic       mode_c;
    logic [7:0] dout_c;

    assign st_lo   = (state_q == ADDR_LO);
    assign st_hi   = (state_q == ADDR_HI);
    assign st_data = (state_q == DATA);
    assign tick    = st_lo | st_hi | st_data;
    assign is_rd   = st_data &
                     ((op_q == OP_VRD) | (op_q == OP_STAT));

    assign bus.cmd_ready = ~reset & (state_q == IDLE) &
                           (cnt_q == 8'd0);
    assign accept = bus.cmd_valid & bus.cmd_ready;
    assign hit    = sh_vld_q & (bus.cmd_addr == sh_addr_q) &
                    (sh_rd_q == (bus.cmd_op == OP_VRD));

    assign bus.wr_tick   = tick & ~is_rd;
    assign bus.rd_tick   = is_rd;
    assign bus.mode      = mode_c;
    assign bus.dout      = dout_c;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_data  = rsp_dat_q;

    always_comb begin
        mode_c = 1'b0;
        dout_c = 8'h00;
        unique case (1'b1)
            st_lo: begin
                mode_c = 1'b1;
                dout_c = (op_q == OP_REG) ?
                         data_q : addr_q[7:0];
            end
            st_hi: begin
                mode_c = 1'b1;
                dout_c = (op_q == OP_REG) ?
                         {5'b10000, addr_q[2:0]} :
                         {1'b0, op_q == OP_VWR,
                          addr_q[13:8]};
            end
            st_data: begin
                mode_c = (op_q == OP_STAT);
                dout_c = (op_q == OP_VWR) ?
                         data_q : 8'h00;
            end
            default: ;
        endcase
    end

    always_comb begin
        follow = IDLE;
        case (state_q)
            ADDR_LO: follow = ADDR_HI;
            ADDR_HI: follow = (op_q == OP_REG) ?
                              IDLE : DATA;
            default: follow = IDLE;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        next_d    = next_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        sh_addr_d = sh_addr_q;
        sh_rd_d   = sh_rd_q;
        sh_vld_d  = sh_vld_q;
        rsp_vld_d = is_rd;
        rsp_dat_d = is_rd ? bus.din : rsp_dat_q;
        case (state_q)
            IDLE: begin
                if (cnt_q != 8'd0)
                    cnt_d = cnt_q - 8'd1;
                if (accept) begin
                    op_d   = bus.cmd_op;
                    addr_d = bus.cmd_addr;
                    data_d = bus.cmd_data;
                    unique case (bus.cmd_op)
                        OP_REG: begin
                            state_d  = ADDR_LO;
                            sh_vld_d = 1'b0;
                        end
                        OP_STAT: state_d = DATA;
                        default: state_d = hit ?
                                           DATA : ADDR_LO;
                    endcase
                end
            end
            GAPWAIT: begin
                if (cnt_q == 8'd0)
                    state_d = next_q;
                else
                    cnt_d = cnt_q - 8'd1;
            end
            default: begin
                cnt_d = GAP_LD;
                if (follow == IDLE)
                    state_d = IDLE;
                else if (GAP == 0)
                    state_d = follow;
                else begin
                    state_d = GAPWAIT;
                    next_d  = follow;
                end
                if (st_data && op_q != OP_STAT) begin
                    sh_addr_d = addr_q + 14'd1;
                    sh_rd_d   = (op_q == OP_VRD);
                    sh_vld_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            next_q    <= IDLE;
            cnt_q     <= 8'd0;
            op_q      <= OP_REG;
            addr_q    <= 14'd0;
            data_q    <= 8'd0;
            sh_addr_q <= 14'd0;
            sh_rd_q   <= 1'b0;
            sh_vld_q  <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            next_q    <= next_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sh_addr_q <= sh_addr_d;
            sh_rd_q   <= sh_rd_d;
            sh_vld_q  <= sh_vld_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end
endmodule

// File: tb/tb_vdp_host_seq.sv
// Directed bench for vdp_host_seq: command vector table plus reset corners.
module tb_vdp_host_seq;
    localparam int G = 4;

    typedef struct {
        logic [1:0]       op;
        logic [13:0]      addr;
        logic [7:0]       data;
        logic [7:0]       din;
        int               n;
        logic [2:0]       rd;
        logic [2:0]       md;
        logic [2:0][7:0]  dv;
    } vec_t;

    logic pxclk = 1'b0;
    logic reset = 1'b1;
    vdp_host_seq_if bus();

    vdp_host_seq #(.GAP(G)) dut (
        .pxclk(pxclk),
        .reset(reset),
        .bus(bus)
    );

    always #5 pxclk = ~pxclk;

    int nchk = 0;
    int nerr = 0;

    int t_n, rsp_n, rsp_cyc, rdy_cyc, bad;
    int t_cyc [8];
    logic t_rd [8];
    logic t_md [8];
    logic [7:0] t_do [8];
    logic [7:0] rsp_dat;

    vec_t vt [14];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] op, input logic [13:0] a,
        input logic [7:0] d, input logic [7:0] di,
        input int n, input logic [2:0] rd, input logic [2:0] md,
        input logic [7:0] d0, input logic [7:0] d1,
        input logic [7:0] d2);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.din = di;
        v.n = n; v.rd = rd; v.md = md;
        v.dv = {d2, d1, d0};
        return v;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [13:0] a,
                         input logic [7:0] d);
        int w;
        w = 0;
        forever begin
            @(negedge pxclk);
            if (bus.cmd_ready === 1'b1) break;
            w++;
            if (w > 60) begin
                $display("FAIL ready_timeout: got 0, expected 1");
                nerr++;
                $display("Simulation finished: %0d checks, %0d errors",
                         nchk, nerr);
                $fatal(1, "ready timeout");
            end
        end
        bus.cmd_op = op;
        bus.cmd_addr = a;
        bus.cmd_data = d;
        bus.cmd_valid = 1'b1;
        @(posedge pxclk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic observe(input int ncyc);
        t_n = 0; rsp_n = 0; rsp_cyc = -1; rdy_cyc = -1; bad = 0;
        rsp_dat = 8'h00;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge pxclk);
            if (bus.wr_tick && bus.rd_tick) bad++;
            if (bus.wr_tick || bus.rd_tick) begin
                if (t_n < 8) begin
                    t_cyc[t_n] = c;
                    t_rd[t_n] = bus.rd_tick;
                    t_md[t_n] = bus.mode;
                    t_do[t_n] = bus.dout;
                end
                t_n++;
            end else if (bus.mode !== 1'b0 || bus.dout !== 8'h00)
                bad++;
            if (bus.rsp_valid) begin
                rsp_n++;
                rsp_cyc = c;
                rsp_dat = bus.rsp_data;
            end
            if (bus.cmd_ready && rdy_cyc < 0 && t_n > 0 &&
                t_n <= 8 && c > t_cyc[t_n-1])
                rdy_cyc = c;
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int lt, act, exp, rdk;
        string s;
        bus.din = v.din;
        issue(v.op, v.addr, v.data);
        observe(18);
        $sformat(s, "v%0d_ntick", id);
        chk(s, t_n, v.n);
        $sformat(s, "v%0d_proto", id);
        chk(s, bad, 0);
        rdk = -1;
        for (int k = 0; k < v.n && k < t_n; k++) begin
            act = (t_cyc[k] << 16) | (int'(t_rd[k]) << 9) |
                  (int'(t_md[k]) << 8) | int'(t_do[k]);
            exp = ((1 + k * (G + 1)) << 16) | (int'(v.rd[k]) << 9) |
                  (int'(v.md[k]) << 8) |
                  (v.rd[k] ? 0 : int'(v.dv[k]));
            $sformat(s, "v%0d_tick%0d", id, k);
            chk(s, act, exp);
            if (v.rd[k]) rdk = 1 + k * (G + 1);
        end
        lt = 1 + (v.n - 1) * (G + 1);
        $sformat(s, "v%0d_ready", id);
        chk(s, rdy_cyc, lt + G);
        $sformat(s, "v%0d_rsp", id);
        if (rdk >= 0)
            chk(s, (rsp_n << 16) | (rsp_cyc << 8) | int'(rsp_dat),
                (1 << 16) | ((rdk + 1) << 8) | int'(v.din));
        else
            chk(s, rsp_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'd0;
        bus.cmd_addr = 14'd0;
        bus.cmd_data = 8'd0;
        bus.din = 8'd0;

        vt[0]  = mk(2'd0, 14'h0001, 8'hE0, 8'h00, 2, 3'b000, 3'b011,
                    8'hE0, 8'h81, 8'h00);
        vt[1]  = mk(2'd1, 14'h1234, 8'h5A, 8'h00, 3, 3'b000, 3'b011,
                    8'h34, 8'h52, 8'h5A);
        vt[2]  = mk(2'd1, 14'h1235, 8'h11, 8'h00, 1, 3'b000, 3'b000,
                    8'h11, 8'h00, 8'h00);
        vt[3]  = mk(2'd1, 14'h1237, 8'h22, 8'h00, 3, 3'b000, 3'b011,
                    8'h37, 8'h52, 8'h22);
        vt[4]  = mk(2'd2, 14'h0100, 8'h00, 8'hC3, 3, 3'b100, 3'b011,
                    8'h00, 8'h01, 8'h00);
        vt[5]  = mk(2'd1, 14'h0101, 8'h33, 8'h00, 3, 3'b000, 3'b011,
                    8'h01, 8'h41, 8'h33);
        vt[6]  = mk(2'd3, 14'h0000, 8'h00, 8'h80, 1, 3'b001, 3'b001,
                    8'h00, 8'h00, 8'h00);
        vt[7]  = mk(2'd1, 14'h0102, 8'h44, 8'h00, 1, 3'b000, 3'b000,
                    8'h44, 8'h00, 8'h00);
        vt[8]  = mk(2'd1, 14'h3FFF, 8'h55, 8'h00, 3, 3'b000, 3'b011,
                    8'hFF, 8'h7F, 8'h55);
        vt[9]  = mk(2'd1, 14'h0000, 8'h66, 8'h00, 1, 3'b000, 3'b000,
                    8'h66, 8'h00, 8'h00);
        vt[10] = mk(2'd0, 14'h0007, 8'h12, 8'h00, 2, 3'b000, 3'b011,
                    8'h12, 8'h87, 8'h00);
        vt[11] = mk(2'd1, 14'h0001, 8'h77, 8'h00, 3, 3'b000, 3'b011,
                    8'h01, 8'h40, 8'h77);
        vt[12] = mk(2'd2, 14'h0002, 8'h00, 8'h5A, 3, 3'b100, 3'b011,
                    8'h02, 8'h00, 8'h00);
        vt[13] = mk(2'd2, 14'h0003, 8'h00, 8'hA5, 1, 3'b001, 3'b000,
                    8'h00, 8'h00, 8'h00);

        repeat (3) @(negedge pxclk);
        chk("rst_ready", int'(bus.cmd_ready), 0);
        chk("rst_outs", int'({bus.wr_tick, bus.rd_tick, bus.mode,
            bus.rsp_valid}), 0);
        chk("rst_bytes", int'({bus.dout, bus.rsp_data}), 0);
        reset = 1'b0;
        #1 chk("rel_ready", int'(bus.cmd_ready), 1);

        foreach (vt[i]) run_vec(i, vt[i]);

        run_vec(20, mk(2'd1, 14'h0200, 8'h01, 8'h00, 3, 3'b000,
                       3'b011, 8'h00, 8'h42, 8'h01));
        issue(2'd1, 14'h0300, 8'h03);
        @(negedge pxclk);
        chk("mid_tick0", int'({bus.wr_tick, bus.mode, bus.dout}),
            int'({1'b1, 1'b1, 8'h00}));
        @(negedge pxclk);
        reset = 1'b1;
        @(negedge pxclk);
        chk("mid_rst_ready", int'(bus.cmd_ready), 0);
        chk("mid_rst_outs", int'({bus.wr_tick, bus.rd_tick, bus.mode,
            bus.dout}), 0);
        @(negedge pxclk);
        reset = 1'b0;
        #1 chk("mid_rel_ready", int'(bus.cmd_ready), 1);
        observe(14);
        chk("mid_no_ticks", t_n, 0);
        chk("mid_no_rsp", rsp_n, 0);
        run_vec(21, mk(2'd1, 14'h0201, 8'h02, 8'h00, 3, 3'b000,
                       3'b011, 8'h01, 8'h42, 8'h02));

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end
endmodule
